// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: in-order circular buffer with PC stall back-pressure.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enq_valid,
  input  logic [WIDTH-1:0]         enq_pc,
  input  logic [WIDTH-1:0]         enq_instr,
  output logic                     stall,
  output logic                     deq_valid,
  output logic [WIDTH-1:0]         deq_pc,
  output logic [WIDTH-1:0]         deq_instr,
  input  logic                     deq_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic full;
  logic empty;
  logic bypass;
  logic do_enq;
  logic do_deq;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue with a ready consumer forwards the pair without storing it.
  assign bypass = empty && enq_valid && deq_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign do_enq = enq_valid && !full && !flush && !bypass;
  assign do_deq = !empty && deq_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (do_enq) begin
      pc_mem[wr_ptr_reg]    <= enq_pc;
      instr_mem[wr_ptr_reg] <= enq_instr;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_deq) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_enq, do_deq})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    deq_valid = !empty && !flush;
    deq_pc    = pc_mem[rd_ptr_reg];
    deq_instr = instr_mem[rd_ptr_reg];
    if (bypass) begin
      deq_valid = 1'b1;
      deq_pc    = enq_pc;
      deq_instr = enq_instr;
    end
  end

  assign stall = full;
  assign count = count_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue: table of per-cycle vectors plus reset and wrap-around sequences.
module tb_fetch_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enq_valid;
  logic [WIDTH-1:0] enq_pc;
  logic [WIDTH-1:0] enq_instr;
  logic             stall;
  logic             deq_valid;
  logic [WIDTH-1:0] deq_pc;
  logic [WIDTH-1:0] deq_instr;
  logic             deq_ready;
  logic             flush;
  logic [2:0]       count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic        dr;
    logic        fl;
    logic [2:0]  cnt;
    logic        dv;
    logic [31:0] dpc;
    logic        st;
  } vec_t;

  vec_t vq[$];

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_instr(enq_instr),
    .stall(stall),
    .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_instr(deq_instr),
    .deq_ready(deq_ready), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  assign enq_instr = instr_of(enq_pc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ev, input logic [31:0] pc, input logic dr, input logic fl,
                     input logic [2:0] cnt, input logic dv, input logic [31:0] dpc, input logic st);
    vec_t v;
    v.ev = ev; v.pc = pc; v.dr = dr; v.fl = fl;
    v.cnt = cnt; v.dv = dv; v.dpc = dpc; v.st = st;
    vq.push_back(v);
  endtask

  // Occupancy must stay within 0..DEPTH; an underflow wraps to a large value.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && count > 3'(DEPTH)) begin
      n_err++;
      $display("FAIL count_range: got %0d, expected at most %0d", count, DEPTH);
    end
  end

  initial begin
    int pc_idx;
    int rx;
    int occ;
    logic acc, dq, byp;

    reset_n = 1'b0; enq_valid = 1'b0; enq_pc = '0; deq_ready = 1'b0; flush = 1'b0;

    // Fill to full, held PC, one dequeue releases stall, then drain.
    add(1, 32'h00, 0, 0, 0, 0, 32'h00, 0);
    add(1, 32'h04, 0, 0, 1, 1, 32'h00, 0);
    add(1, 32'h08, 0, 0, 2, 1, 32'h00, 0);
    add(1, 32'h0C, 0, 0, 3, 1, 32'h00, 0);
    add(1, 32'h10, 0, 0, 4, 1, 32'h00, 1);
    add(1, 32'h10, 1, 0, 4, 1, 32'h00, 1);
    add(1, 32'h10, 0, 0, 3, 1, 32'h04, 0);
    add(0, 32'h00, 1, 0, 4, 1, 32'h04, 1);
    add(0, 32'h00, 1, 0, 3, 1, 32'h08, 0);
    add(0, 32'h00, 1, 0, 2, 1, 32'h0C, 0);
    add(0, 32'h00, 1, 0, 1, 1, 32'h10, 0);
    // Concurrent enqueue/dequeue at count 2.
    add(1, 32'h20, 0, 0, 0, 0, 32'h00, 0);
    add(1, 32'h24, 0, 0, 1, 1, 32'h20, 0);
    add(1, 32'h28, 1, 0, 2, 1, 32'h20, 0);
    add(0, 32'h00, 1, 0, 2, 1, 32'h24, 0);
    add(0, 32'h00, 1, 0, 1, 1, 32'h28, 0);
    // Flush at count 3 with a same-cycle enqueue that must be discarded.
    add(1, 32'h30, 0, 0, 0, 0, 32'h00, 0);
    add(1, 32'h34, 0, 0, 1, 1, 32'h30, 0);
    add(1, 32'h38, 0, 0, 2, 1, 32'h30, 0);
    add(1, 32'h40, 1, 1, 3, 0, 32'h00, 0);
    add(1, 32'h80, 0, 0, 0, 0, 32'h00, 0);
    add(0, 32'h00, 1, 0, 1, 1, 32'h80, 0);
    add(0, 32'h00, 0, 0, 0, 0, 32'h00, 0);
    // Empty queue, enqueue with ready consumer.
`ifdef FETCH_QUEUE_BYPASS_EN
    add(1, 32'h100, 1, 0, 0, 1, 32'h100, 0);
    add(0, 32'h000, 1, 0, 0, 0, 32'h000, 0);
`else
    add(1, 32'h100, 1, 0, 0, 0, 32'h000, 0);
    add(0, 32'h000, 1, 0, 1, 1, 32'h100, 0);
`endif
    add(0, 32'h000, 0, 0, 0, 0, 32'h000, 0);

    #12;
    chk("reset count", 32'(count), 0);
    chk("reset deq_valid", 32'(deq_valid), 0);
    chk("reset stall", 32'(stall), 0);
    chk("reset deq_pc", deq_pc, 0);
    chk("reset deq_instr", deq_instr, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      enq_valid = vq[i].ev; enq_pc = vq[i].pc; deq_ready = vq[i].dr; flush = vq[i].fl;
      @(negedge clk);
      $display("row %0d: ev=%0d pc=0x%0h dr=%0d fl=%0d -> count=%0d deq_valid=%0d deq_pc=0x%0h stall=%0d",
               i, enq_valid, enq_pc, deq_ready, flush, count, deq_valid, deq_pc, stall);
      chk($sformatf("row%0d count", i), 32'(count), 32'(vq[i].cnt));
      chk($sformatf("row%0d deq_valid", i), 32'(deq_valid), 32'(vq[i].dv));
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(vq[i].st));
      if (vq[i].dv) begin
        chk($sformatf("row%0d deq_pc", i), deq_pc, vq[i].dpc);
        chk($sformatf("row%0d deq_instr", i), deq_instr, instr_of(vq[i].dpc));
      end
    end

    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      enq_valid = 1'b1; enq_pc = 32'h200 + 32'(4 * i); deq_ready = 1'b0; flush = 1'b0;
    end
    @(posedge clk); #1;
    enq_valid = 1'b0;
    chk("pre-reset count", 32'(count), 3);
    #2 reset_n = 1'b0;
    #1;
    $display("async reset: count=%0d deq_valid=%0d stall=%0d deq_pc=0x%0h", count, deq_valid, stall, deq_pc);
    chk("async count", 32'(count), 0);
    chk("async deq_valid", 32'(deq_valid), 0);
    chk("async stall", 32'(stall), 0);
    chk("async deq_pc", deq_pc, 0);
    chk("async deq_instr", deq_instr, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Wrap-around stream of 10 pairs with deq_ready pattern 1,0,0,1.
    pc_idx = 0; rx = 0; occ = 0;
    for (int cyc = 0; cyc < 200 && rx < 10; cyc++) begin
      @(posedge clk); #1;
      enq_valid = (pc_idx < 10);
      enq_pc    = 32'(pc_idx * 4);
      deq_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      flush     = 1'b0;
      @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
      byp = (occ == 0) && enq_valid && deq_ready;
`else
      byp = 1'b0;
`endif
      acc = enq_valid && (occ != DEPTH);
      dq  = ((occ != 0) || byp) && deq_ready;
      chk($sformatf("wrap%0d count", cyc), 32'(count), 32'(occ));
      chk($sformatf("wrap%0d stall", cyc), 32'(stall), 32'(occ == DEPTH));
      chk($sformatf("wrap%0d deq_valid", cyc), 32'(deq_valid), 32'((occ != 0) || byp));
      if (dq) begin
        $display("wrap cycle %0d: received pc=0x%0h (expected 0x%0h)", cyc, deq_pc, rx * 4);
        chk($sformatf("wrap%0d order", cyc), deq_pc, 32'(rx * 4));
        rx++;
      end
      if (!byp) occ = occ + int'(acc) - int'(dq);
      if (acc) pc_idx++;
    end
    chk("wrap received", 32'(rx), 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the IF stage and ID in the pipelined CPU. It is the consumer end of the program-counter register's fetch stream: it accepts one (pc, instruction) pair per cycle, buffers up to DEPTH pairs in order, and hands them to decode with a valid/ready handshake. It drives the PC register's active-high stall input when it cannot accept, so no fetched pair is lost. Branch redirects discard all buffered contents.

## Interface

- WIDTH, 32: PC and instruction width in bits.
- DEPTH, 4: entry count; power of two, ≥ 2.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- enq_valid  in  1  IF presents a fetched pair this cycle.
- enq_pc  in  WIDTH  PC of the fetched instruction.
- enq_instr  in  WIDTH  fetched instruction word.
- stall  out  1  connects to the PC's update_n; high holds the PC.
- deq_valid  out  1  head entry available to ID.
- deq_pc  out  WIDTH  PC of the head entry.
- deq_instr  out  WIDTH  instruction of the head entry.
- deq_ready  in  1  ID accepts the head this cycle.
- flush  in  1  branch redirect; discards all contents.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Circular buffer with read pointer, write pointer and occupancy counter. Storage is reset to 0.
- Enqueue at posedge when enq_valid && !full && !flush. The pair is written at the write pointer, and the write pointer wraps modulo DEPTH.
- Dequeue at posedge when deq_valid && deq_ready && !flush. The read pointer advances and wraps modulo DEPTH.
- stall = full (count == DEPTH). It is purely registered-state derived, with no path from deq_ready or enq_valid.
- A pair presented while full is refused. The PC holds, so IF re-presents the same pair until it is accepted.
- Full with a dequeue in the same cycle: the enqueue is still refused, count goes to DEPTH−1, and stall drops.
- Enqueue and dequeue in the same cycle when not full: count is unchanged and FIFO order is preserved.
- deq_valid = (count != 0) && !flush. deq_pc and deq_instr show the entry at the read pointer.
- Flush has priority over everything. At the next posedge, both pointers and count go to 0, and any same-cycle enqueue or handshake is discarded.
- Empty with no bypass: deq_valid is 0 and deq_ready is ignored.
- Reset, including mid-operation: pointers, count and storage are cleared immediately (asynchronous). deq_valid=0, deq_pc=0, deq_instr=0, stall=0, count=0.

## Timing

- Latency without bypass: an entry enqueued at edge N is visible on deq_* in cycle N+1.
- stall rises in the cycle after the enqueue that makes count reach DEPTH. It falls in the cycle after the first dequeue from full.
- Flush asserted in cycle N: deq_valid is 0 during cycle N and the queue is empty from edge N+1. An enqueue in cycle N+1 is accepted normally.
- Occupancy never exceeds DEPTH or underflows below 0. The verification bench asserts both.

## Configuration

- FETCH_QUEUE_BYPASS_EN defined: when count==0, enq_valid=1, deq_ready=1 and flush=0, the enqueued pair goes combinationally to deq_* in the same cycle with deq_valid=1. It is not written, and count stays 0. If empty, enq_valid=1 and deq_ready=0, the pair is written normally.
- Not defined: no combinational enq→deq path, and the minimum latency is 1 cycle.

## Test plan

- Async reset: queue holds 3 entries and reset_n goes low between edges → count=0, deq_valid=0, stall=0, deq_pc=0 immediately, before the next edge.
- Fill/stall, DEPTH=4, deq_ready=0: enqueue PCs 0x0, 0x4, 0x8, 0xC → count=4 and stall=1. PC 0x10 is held and not accepted. One cycle of deq_ready=1 dequeues 0x0 → count=3 and stall=0. The next edge accepts 0x10.
- Concurrent enqueue and dequeue at count=2 (heads 0x20, 0x24), enqueue 0x28 → count stays 2, deq_pc=0x24 next cycle, order 0x24, 0x28 thereafter.
- Flush at count=3 with enq_valid=1 (PC 0x40) → deq_valid=0 in the flush cycle, count=0 after the edge, 0x40 never emerges. An enqueue of 0x80 in the next cycle emerges first.
- Wrap-around: stream 10 pairs 0x0..0x24 with deq_ready toggling 1,0,0,1,… → ID receives exactly 0x0, 0x4, …, 0x24 in order, with no drops or duplicates, and stall asserts only when count=4.
- Bypass: empty queue, enq 0x100 with deq_ready=1 → with FETCH_QUEUE_BYPASS_EN, deq_valid=1 and deq_pc=0x100 in the same cycle, count stays 0. Without the macro, deq_valid=1 only in the next cycle.
